// File: rtl/gelato_inst_buffer_if.sv
// Decode-to-issue handshake bundle for the per-warp instruction buffer.
// The producer/scheduler side takes the master modport and the buffer takes the slave modport.
interface gelato_inst_buffer_if #(
  parameter int NUM_WARPS  = 4,
  parameter int INST_WIDTH = 64
);
  localparam int WARP_W = $clog2(NUM_WARPS);

  logic                  rdy;
  logic                  fetch_req;
  logic [WARP_W-1:0]     fetch_warp;
  logic [NUM_WARPS-1:0]  can_fetch;
  logic                  push_valid;
  logic [WARP_W-1:0]     push_warp;
  logic [INST_WIDTH-1:0] push_inst;
  logic                  flush;
  logic [WARP_W-1:0]     flush_warp;
  logic [WARP_W-1:0]     issue_warp;
  logic                  issue_valid;
  logic [INST_WIDTH-1:0] issue_inst;
  logic                  issue_pop;
  logic [NUM_WARPS-1:0]  head_valid;
  logic                  overflow;

  modport master (
    output rdy, fetch_req, fetch_warp, push_valid, push_warp, push_inst,
           flush, flush_warp, issue_warp, issue_pop,
    input  can_fetch, issue_valid, issue_inst, head_valid, overflow
  );

  modport slave (
    input  rdy, fetch_req, fetch_warp, push_valid, push_warp, push_inst,
           flush, flush_warp, issue_warp, issue_pop,
    output can_fetch, issue_valid, issue_inst, head_valid, overflow
  );
endinterface

// File: rtl/gelato_inst_buffer.sv
// Per-warp decoded-instruction FIFO between decode and issue.
// Tracks in-flight fetches so that a flushed warp drops stale returns.
module gelato_inst_buffer #(
  parameter int NUM_WARPS  = 4,
  parameter int DEPTH      = 2,
  parameter int INST_WIDTH = 64
) (
  input logic clk,
  input logic rst_n,  // active-high asynchronous reset despite the name
  gelato_inst_buffer_if.slave bus
);
  localparam int WARP_W = $clog2(NUM_WARPS);
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [PTR_W-1:0] PTR_LAST  = PTR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W:0]   DEPTH_EXT = (CNT_W + 1)'(DEPTH);

  typedef struct packed {
    logic [PTR_W-1:0] rd;
    logic [PTR_W-1:0] wr;
    logic [CNT_W-1:0] occ;
    logic [CNT_W-1:0] resv;
    logic [CNT_W-1:0] drop;
  } warp_st_t;

  warp_st_t              r_st     [NUM_WARPS];
  warp_st_t              w_st_nxt [NUM_WARPS];
  logic [INST_WIDTH-1:0] r_mem    [NUM_WARPS][DEPTH];
  logic                  r_overflow;
  logic                  w_overflow_nxt;

  logic [NUM_WARPS-1:0] w_can_fetch;
  logic [NUM_WARPS-1:0] w_head_valid;
  logic [NUM_WARPS-1:0] w_fetch_hit;
  logic [NUM_WARPS-1:0] w_fetch_ok;
  logic [NUM_WARPS-1:0] w_push_hit;
  logic [NUM_WARPS-1:0] w_push_ok;
  logic [NUM_WARPS-1:0] w_flush_hit;
  logic [NUM_WARPS-1:0] w_pop_ok;
  logic [NUM_WARPS-1:0] w_wr_en;

  // Circular pointers wrap explicitly so DEPTH need not be a power of two.
  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    w_can_fetch  = '0;
    w_head_valid = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_can_fetch[w]  = ({1'b0, r_st[w].occ} + {1'b0, r_st[w].resv}) < DEPTH_EXT;
      w_head_valid[w] = (r_st[w].occ != '0);
    end
  end

  assign bus.can_fetch   = w_can_fetch;
  assign bus.head_valid  = w_head_valid;
  assign bus.overflow    = r_overflow;
  assign bus.issue_valid = w_head_valid[bus.issue_warp];
  assign bus.issue_inst  = w_head_valid[bus.issue_warp]
                         ? r_mem[bus.issue_warp][r_st[bus.issue_warp].rd] : '0;

  // NOTE: every signal driven here gets a default before any conditional
  // assignment, so no path leaves a value held and no latch is inferred.
  always_comb begin
    w_overflow_nxt = r_overflow;
    w_fetch_hit    = '0;
    w_fetch_ok     = '0;
    w_push_hit     = '0;
    w_push_ok      = '0;
    w_flush_hit    = '0;
    w_pop_ok       = '0;
    w_wr_en        = '0;
    for (int w = 0; w < NUM_WARPS; w++) begin
      w_st_nxt[w]    = r_st[w];
      w_fetch_hit[w] = bus.fetch_req  && (bus.fetch_warp == WARP_W'(w));
      w_push_hit[w]  = bus.push_valid && (bus.push_warp  == WARP_W'(w));
      w_flush_hit[w] = bus.flush      && (bus.flush_warp == WARP_W'(w));
      w_fetch_ok[w]  = w_fetch_hit[w] && w_can_fetch[w];
      w_push_ok[w]   = w_push_hit[w]  && (r_st[w].resv != '0);
      w_pop_ok[w]    = bus.issue_pop && (bus.issue_warp == WARP_W'(w))
                     && w_head_valid[w] && !w_flush_hit[w];

      if ((w_fetch_hit[w] && !w_can_fetch[w]) || (w_push_hit[w] && !w_push_ok[w]))
        w_overflow_nxt = 1'b1;

      w_st_nxt[w].resv = r_st[w].resv - CNT_W'(w_push_ok[w]);

      if (w_flush_hit[w]) begin
        // Everything fetched before the flush is stale, including what is still in flight.
        w_st_nxt[w].rd   = '0;
        w_st_nxt[w].wr   = '0;
        w_st_nxt[w].occ  = '0;
        w_st_nxt[w].drop = w_st_nxt[w].resv;
      end else begin
        if (w_push_ok[w]) begin
          if (r_st[w].drop != '0) begin
            w_st_nxt[w].drop = r_st[w].drop - CNT_ONE;
          end else begin
            w_wr_en[w]     = 1'b1;
            w_st_nxt[w].wr = ptr_inc(r_st[w].wr);
          end
        end
        if (w_pop_ok[w])
          w_st_nxt[w].rd = ptr_inc(r_st[w].rd);
        w_st_nxt[w].occ = r_st[w].occ + CNT_W'(w_wr_en[w]) - CNT_W'(w_pop_ok[w]);
      end

      // A fetch in the flush cycle belongs to the new stream, so it is not dropped.
      w_st_nxt[w].resv = w_st_nxt[w].resv + CNT_W'(w_fetch_ok[w]);
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int w = 0; w < NUM_WARPS; w++)
        r_st[w] <= '0;
      r_overflow <= 1'b0;
    end else if (bus.rdy) begin
      for (int w = 0; w < NUM_WARPS; w++)
        r_st[w] <= w_st_nxt[w];
      r_overflow <= w_overflow_nxt;
    end
  end

  // NOTE: payload storage is deliberately not reset; occ gates every read,
  // so stale contents are never observable.
  always_ff @(posedge clk) begin
    if (bus.rdy) begin
      for (int w = 0; w < NUM_WARPS; w++)
        if (w_wr_en[w])
          r_mem[w][r_st[w].wr] <= bus.push_inst;
    end
  end
endmodule
